cordic_phase_sequencer: RTL
===========================

Name: cordic_phase_sequencer

Overview:
Upstream driver for the 8-bit CORDIC sine core.
- Owns a 0..359 degree phase accumulator and folds each phase into the core's 0..90 degree input range.
- Issues one angle per transaction to the core using a start/done handshake.
- Applies the quadrant sign to the core's y result and presents a signed sine sample with a one-cycle valid strobe.

Parameters:
TIMEOUT_CYCLES, 31, maximum number of WAIT cycles allowed for core_done before the transaction is abandoned.
GAP_CYCLES, 0, number of idle cycles inserted after each transaction before the next issue (sets the sample rate).

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
ena  input  1  global enable; when low, all state is frozen
run  input  1  level; high = keep generating samples
step_deg  input  8  phase increment in degrees; values above 179 are clamped to 179
core_start  output  1  single-cycle pulse requesting one CORDIC evaluation
core_alpha  output  8  folded angle in degrees, 0..90
core_done  input  1  core result valid; sampled only in WAIT
core_y  input  8  signed core sine result
sample  output  8  signed sine sample; holds its value between updates
sample_valid  output  1  single-cycle strobe, asserted when sample updates
quadrant  output  2  quadrant of the phase currently in flight
busy  output  1  high in ISSUE and WAIT
timeout_err  output  1  sticky timeout flag; cleared only by reset

Behaviour:
- Reset (async, rst_n low): state=IDLE; phase=0; sample=0; core_alpha=0; quadrant=0; all strobes, busy and timeout_err =0; wait counter=0.
- ena low: no register changes, including counters; strobes hold at 0.
- FSM states: IDLE, ISSUE, WAIT, EMIT, GAP.
- IDLE -> ISSUE when run=1.
- ISSUE (one cycle):
  - core_start=1.
  - core_alpha and quadrant are registered from the fold of the current phase.
  - Next state is WAIT.
- WAIT:
  - core_alpha stays stable.
  - core_done=1 -> capture core_y, go to EMIT.
  - Wait counter reaches TIMEOUT_CYCLES without done -> set timeout_err, skip EMIT, advance phase, go to GAP.
  - core_done seen during ISSUE is ignored.
- EMIT (one cycle):
  - sample and sample_valid=1 are registered, so sample_valid appears exactly one cycle after core_done is seen in WAIT.
  - phase is advanced; next state is GAP.
- GAP: counts GAP_CYCLES (0 = zero extra cycles, pass straight through). Then:
  - run=1 -> ISSUE.
  - run=0 -> IDLE, with phase held.
- Fold rules (phase 9 bits):
  - 0..90: alpha=phase, sign +, q0.
  - 91..180: alpha=180-phase, sign +, q1.
  - 181..270: alpha=phase-180, sign -, q2.
  - 271..359: alpha=360-phase, sign -, q3.
- Sample sign handling:
  - sample = sign ? -core_y : core_y.
  - Negating -128 saturates to +127.
- Phase advance:
  - sum = phase + clamped step, computed in 10 bits.
  - If sum >= 360, subtract 360; the result is always 0..359.
- run dropping during ISSUE/WAIT does not abort: the transaction completes (or times out), then the FSM returns to IDLE.
- Reset mid-WAIT: the core handshake is abandoned. After reset the block issues a new start only once run=1.

Optional Feature:
COS_OUT_EN:
- When defined, adds input core_x[7:0] and outputs cos_sample[7:0] (signed).
- cos_sample is updated in EMIT alongside sample.
- Its sign is negative in q1 and q2, positive in q0 and q3, with the same -128 saturation rule.
- When not defined, these ports and their logic are absent and behaviour is otherwise identical.

Test Plan:
All scenarios use a bench core model that returns core_y = core_alpha, 6 cycles after core_start, unless stated otherwise.
1. Reset: hold rst_n=0 with run=1 -> sample=0, all strobes=0, timeout_err=0, no core_start until 1 cycle after release.
2. step_deg=30, run=1, GAP_CYCLES=0 -> core_alpha sequence 0,30,60,90,60,30,0,30,60,90,60,30,0; samples 0,30,60,90,60,30,0,-30,-60,-90,-60,-30,0; sample_valid 1 cycle after each done.
3. step_deg=200 (clamped to 179) -> phases 0,179,358,177; core_alpha 0,1,2,3; samples 0,1,-2,3.
4. Model never asserts done, TIMEOUT_CYCLES=31 -> timeout_err=1 after 32 WAIT cycles, no sample_valid, next core_start still issued with core_alpha=step.
5. step_deg=100; model returns core_y=-128 on the third transaction (phase 200, q2, alpha 20) -> sample=+127.
6. Deassert run during WAIT -> sample_valid still fires once, then IDLE with phase held; reassert run -> next core_alpha continues from the held phase. Pulse rst_n mid-WAIT -> all outputs return to reset values.

Source files
------------

// File: rtl/cordic_phase_sequencer_if.sv
// Start/done handshake between the phase sequencer (master) and the 8-bit CORDIC sine core.
// Macro COS_OUT_EN adds the core's x (cosine) result to the bundle.
interface cordic_phase_sequencer_if;
  logic       core_start;
  logic [7:0] core_alpha;
  logic       core_done;
  logic [7:0] core_y;
`ifdef COS_OUT_EN
  logic [7:0] core_x;
`endif

  modport master (
    output core_start,
    output core_alpha,
`ifdef COS_OUT_EN
    input  core_x,
`endif
    input  core_done,
    input  core_y
  );

  modport slave (
    input  core_start,
    input  core_alpha,
`ifdef COS_OUT_EN
    output core_x,
`endif
    output core_done,
    output core_y
  );
endinterface

// File: rtl/cordic_phase_sequencer.sv
// Phase accumulator and quadrant folding front-end for the 8-bit CORDIC sine core.
// Optional macro COS_OUT_EN adds a signed cosine output taken from the core's x result.
module cordic_phase_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 31,
  parameter int unsigned GAP_CYCLES     = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ena,
  input  logic                            run,
  input  logic [7:0]                      step_deg,
  cordic_phase_sequencer_if.master        core,
  output logic [7:0]                      sample,
  output logic                            sample_valid,
  output logic [1:0]                      quadrant,
  output logic                            busy,
  output logic                            timeout_err
`ifdef COS_OUT_EN
  ,
  output logic [7:0]                      cos_sample
`endif
);

  localparam int unsigned WaitW = $clog2(TIMEOUT_CYCLES + 2);
  localparam int unsigned GapW  = $clog2(GAP_CYCLES + 2);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StEmit, StGap} state_e;

  state_e            state_q, state_d;
  logic [8:0]        phase_q, phase_d;
  logic [7:0]        alpha_q, alpha_d;
  logic [1:0]        quad_q, quad_d;
  logic [7:0]        sample_q, sample_d;
  logic              timeout_q, timeout_d;
  logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
`ifdef COS_OUT_EN
  logic [7:0]        cos_q, cos_d;
`endif

  logic [7:0] step_c;
  logic [9:0] sum;
  logic [8:0] adv_phase;
  logic [7:0] fold_alpha;
  logic [1:0] fold_quad;
  state_e     post_txn_state;

  function automatic logic [7:0] neg_sat(input logic [7:0] v);
    return (v == 8'h80) ? 8'h7f : (~v + 8'd1);
  endfunction

  assign step_c    = (step_deg > 8'd179) ? 8'd179 : step_deg;
  assign sum       = {1'b0, phase_q} + {2'b00, step_c};
  assign adv_phase = (sum >= 10'd360) ? 9'(sum - 10'd360) : sum[8:0];

  // With no gap configured the GAP state is skipped entirely.
  assign post_txn_state = (GAP_CYCLES == 0) ? (run ? StIssue : StIdle) : StGap;

  // Fold the phase that will be current when ISSUE starts, so core_alpha is valid with core_start.
  always_comb begin
    fold_alpha = 8'(phase_d);
    fold_quad  = 2'd0;
    if (phase_d <= 9'd90) begin
      fold_alpha = 8'(phase_d);
      fold_quad  = 2'd0;
    end else if (phase_d <= 9'd180) begin
      fold_alpha = 8'(9'd180 - phase_d);
      fold_quad  = 2'd1;
    end else if (phase_d <= 9'd270) begin
      fold_alpha = 8'(phase_d - 9'd180);
      fold_quad  = 2'd2;
    end else begin
      fold_alpha = 8'(9'd360 - phase_d);
      fold_quad  = 2'd3;
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    alpha_d    = alpha_q;
    quad_d     = quad_q;
    sample_d   = sample_q;
    timeout_d  = timeout_q;
    wait_cnt_d = wait_cnt_q;
    gap_cnt_d  = gap_cnt_q;
`ifdef COS_OUT_EN
    cos_d      = cos_q;
`endif
    if (ena) begin
      unique case (state_q)
        StIdle: begin
          if (run) state_d = StIssue;
        end
        StIssue: begin
          wait_cnt_d = '0;
          gap_cnt_d  = '0;
          state_d    = StWait;
        end
        StWait: begin
          if (core.core_done) begin
            // Quadrants 2 and 3 carry a negative sine.
            sample_d = quad_q[1] ? neg_sat(core.core_y) : core.core_y;
`ifdef COS_OUT_EN
            cos_d    = (quad_q[1] ^ quad_q[0]) ? neg_sat(core.core_x) : core.core_x;
`endif
            state_d  = StEmit;
          end else if (wait_cnt_q == WaitW'(TIMEOUT_CYCLES)) begin
            timeout_d = 1'b1;
            phase_d   = adv_phase;
            state_d   = post_txn_state;
          end else begin
            wait_cnt_d = wait_cnt_q + WaitW'(1);
          end
        end
        StEmit: begin
          phase_d = adv_phase;
          state_d = post_txn_state;
        end
        StGap: begin
          if (gap_cnt_q == GapW'(GAP_CYCLES - 1)) begin
            state_d = run ? StIssue : StIdle;
          end else begin
            gap_cnt_d = gap_cnt_q + GapW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
    if ((state_d == StIssue) && (state_q != StIssue)) begin
      alpha_d = fold_alpha;
      quad_d  = fold_quad;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      phase_q    <= '0;
      alpha_q    <= '0;
      quad_q     <= '0;
      sample_q   <= '0;
      timeout_q  <= 1'b0;
      wait_cnt_q <= '0;
      gap_cnt_q  <= '0;
`ifdef COS_OUT_EN
      cos_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      alpha_q    <= alpha_d;
      quad_q     <= quad_d;
      sample_q   <= sample_d;
      timeout_q  <= timeout_d;
      wait_cnt_q <= wait_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
`ifdef COS_OUT_EN
      cos_q      <= cos_d;
`endif
    end
  end

  assign core.core_start = ena && (state_q == StIssue);
  assign core.core_alpha = alpha_q;
  assign sample_valid    = ena && (state_q == StEmit);
  assign sample          = sample_q;
  assign quadrant        = quad_q;
  assign busy            = (state_q == StIssue) || (state_q == StWait);
  assign timeout_err     = timeout_q;
`ifdef COS_OUT_EN
  assign cos_sample      = cos_q;
`endif

endmodule
